// File: rtl/pfcache_reqq_pkg.sv
// Shared types for the cache-side prefetch request queue: request payload,
// statistics bundle returned to the prefetch engine, and the queue FSM states.
package pfcache_reqq_pkg;

  localparam int LADDR_W = 40;
  localparam int SPTBR_W = 38;
  localparam int STATS_W = 16;

  typedef struct packed {
    logic [SPTBR_W-1:0] sptbr;
    logic [LADDR_W-1:0] laddr;
  } I_pftocache_req_type;

  // Counters narrower than STATS_W are zero-extended into these fields
  typedef struct packed {
    logic [STATS_W-1:0] nhit;
    logic [STATS_W-1:0] nmiss;
    logic [STATS_W-1:0] ndup;
    logic [STATS_W-1:0] ntimeout;
    logic [STATS_W-1:0] nreq;
  } PF_cache_stats_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } pfq_state_t;

  function automatic logic laddr_eq(input logic [LADDR_W-1:0] a, input logic [LADDR_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/pfcache_reqq_satcnt.sv
// Saturating event counter with a synchronous clear that beats a same-cycle increment.
module pfcache_satcnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count up, stick at all-ones, clear on request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pfcache_reqq.sv
// Per-bank receiver of prefetch requests: dedups and queues lines, issues one
// tag lookup at a time, and reports hit/miss/dup/timeout/request counts.
module pfcache_reqq
  import pfcache_reqq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pfreq_valid,
  output logic                pfreq_retry,
  input  I_pftocache_req_type pfreq,
  output logic                lookup_valid,
  input  logic                lookup_retry,
  output I_pftocache_req_type lookup,
  input  logic                res_valid,
  input  logic                res_hit,
  input  logic                stats_clear,
  output PF_cache_stats_type  pf_stats
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTQ_W = PTR_W + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  I_pftocache_req_type mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNTQ_W-1:0]   count_r;
  logic [CNTQ_W-1:0]   count_next_s;
  logic                full_r;
  pfq_state_t          state_r;
  pfq_state_t          state_next_s;
  logic [TMR_W-1:0]    timer_r;
  logic [LADDR_W-1:0]  inflight_r;

  logic accept_s;
  logic dup_s;
  logic enq_s;
  logic pop_s;
  logic tmo_s;
  logic hit_inc_s;
  logic miss_inc_s;
  logic [PTR_W-1:0] idx_s;

  logic [CNT_W-1:0] nhit_s, nmiss_s, ndup_s, ntimeout_s, nreq_s;

  assign pfreq_retry  = full_r;
  assign accept_s     = pfreq_valid && !full_r;
  assign pop_s        = (state_r == ISSUE) && !lookup_retry;
  assign enq_s        = accept_s && !dup_s;
  assign lookup_valid = (state_r == ISSUE);
  assign lookup       = (state_r == ISSUE) ? mem_r[rd_ptr_r] : '0;
  assign tmo_s        = (state_r == WAIT) && !res_valid && (timer_r == TMR_W'(TIMEOUT - 1));
  assign hit_inc_s    = (state_r == WAIT) && res_valid && res_hit;
  assign miss_inc_s   = (state_r == WAIT) && res_valid && !res_hit;

  // A head being popped this cycle still matches here, standing in for the in-flight copy it becomes
  always_comb begin
    dup_s = 1'b0;
    idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = rd_ptr_r + PTR_W'(i);
      if ((CNTQ_W'(i) < count_r) && laddr_eq(mem_r[idx_s].laddr, pfreq.laddr)) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
    if ((state_r == WAIT) && laddr_eq(inflight_r, pfreq.laddr)) begin
      dup_s = 1'b1;
    end else begin
      dup_s = dup_s;
    end
  end

  // Occupancy after this cycle's enqueue and dequeue
  always_comb begin
    count_next_s = count_r;
    if (enq_s && !pop_s) begin
      count_next_s = count_r + CNTQ_W'(1);
    end else if (!enq_s && pop_s) begin
      count_next_s = count_r - CNTQ_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Lookup sequencing
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != {CNTQ_W{1'b0}}) state_next_s = ISSUE;
        else state_next_s = IDLE;
      end
      ISSUE: begin
        if (pop_s) state_next_s = WAIT;
        else state_next_s = ISSUE;
      end
      WAIT: begin
        if (res_valid || tmo_s) begin
          state_next_s = (count_next_s != {CNTQ_W{1'b0}}) ? ISSUE : IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Queue storage; contents beyond count are don't-care so no reset needed
  always_ff @(posedge clk) begin
    if (enq_s) mem_r[wr_ptr_r] <= pfreq;
  end

  // Pointers, occupancy, FSM state, timer and in-flight address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNTQ_W{1'b0}};
      full_r     <= 1'b0;
      state_r    <= IDLE;
      timer_r    <= {TMR_W{1'b0}};
      inflight_r <= {LADDR_W{1'b0}};
    end else begin
      wr_ptr_r <= enq_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      count_r  <= count_next_s;
      full_r   <= (count_next_s == CNTQ_W'(DEPTH));
      state_r  <= state_next_s;
      if (pop_s) begin
        timer_r    <= {TMR_W{1'b0}};
        inflight_r <= mem_r[rd_ptr_r].laddr;
      end else if (state_r == WAIT) begin
        timer_r    <= timer_r + TMR_W'(1);
        inflight_r <= inflight_r;
      end else begin
        timer_r    <= timer_r;
        inflight_r <= inflight_r;
      end
    end
  end

  pfcache_satcnt #(.CNT_W(CNT_W)) u_nhit (
    .clk(clk), .reset(reset), .inc(hit_inc_s), .clr(stats_clear), .cnt(nhit_s)
  );
  pfcache_satcnt #(.CNT_W(CNT_W)) u_nmiss (
    .clk(clk), .reset(reset), .inc(miss_inc_s), .clr(stats_clear), .cnt(nmiss_s)
  );
  pfcache_satcnt #(.CNT_W(CNT_W)) u_ndup (
    .clk(clk), .reset(reset), .inc(accept_s && dup_s), .clr(stats_clear), .cnt(ndup_s)
  );
  pfcache_satcnt #(.CNT_W(CNT_W)) u_ntimeout (
    .clk(clk), .reset(reset), .inc(tmo_s), .clr(stats_clear), .cnt(ntimeout_s)
  );
  pfcache_satcnt #(.CNT_W(CNT_W)) u_nreq (
    .clk(clk), .reset(reset), .inc(accept_s), .clr(stats_clear), .cnt(nreq_s)
  );

  assign pf_stats.nhit     = STATS_W'(nhit_s);
  assign pf_stats.nmiss    = STATS_W'(nmiss_s);
  assign pf_stats.ndup     = STATS_W'(ndup_s);
  assign pf_stats.ntimeout = STATS_W'(ntimeout_s);
  assign pf_stats.nreq     = STATS_W'(nreq_s);

endmodule
